net_fanout_fork: RTL and testbench

Registered stream fork that drives one source onto a high-fanout net of FANOUT sink cells. It sits directly upstream of the fanout cluster: each sink gets its own valid/ready pair, so one slow sink never forces a combinational stall across the whole net. A small input FIFO decouples the source. A word is retired only after every sink has accepted it.

---
 rtl/net_fanout_fork.sv | 89 ++++++++
 tb/tb_net_fanout_fork.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/net_fanout_fork.sv
// Registered stream fork: one source, a small input FIFO, and FANOUT independent
// valid/ready sinks. The head word retires only once every sink has taken it.
module net_fanout_fork #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FANOUT = 20,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic [FANOUT-1:0]          out_valid,
    input  logic [FANOUT-1:0]          out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [FANOUT-1:0]          pending,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [FANOUT-1:0] done_q, done_d;

    logic              nonempty;
    logic              push;
    logic              retire;
    logic [FANOUT-1:0] take;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready looks only at registered occupancy, so a full FIFO refuses a
    // push even while the head retires; this keeps out_ready off the source path.
    assign nonempty  = (count_q != '0);
    assign in_ready  = (count_q < CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign out_valid = {FANOUT{nonempty}} & ~done_q;
    assign pending   = out_valid;
    assign take      = out_valid & out_ready;
    assign retire    = nonempty & (&(done_q | take));
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        done_d   = done_q | take;
        if (push) begin
            wr_ptr_d = wrap_inc(wr_ptr_q);
        end
        if (retire) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
            done_d   = '0;
        end
        case ({push, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_net_fanout_fork.sv
// Directed vector table plus hand-written sequences for net_fanout_fork
// (WIDTH=8, FANOUT=20, DEPTH=2).
module tb_net_fanout_fork;

    localparam int unsigned W  = 8;
    localparam int unsigned F  = 20;
    localparam int unsigned D  = 2;
    localparam int unsigned CW = $clog2(D + 1);
    localparam logic [F-1:0] ALL = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [F-1:0]  out_valid;
    logic [F-1:0]  out_ready;
    logic [W-1:0]  out_data;
    logic [F-1:0]  pending;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    net_fanout_fork #(.WIDTH(W), .FANOUT(F), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pending   (pending),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic [F-1:0] rdy;
        logic [1:0]   ecnt;
        logic [F-1:0] eov;
        logic [W-1:0] edata;
        logic         chkd;
        logic         eir;
    } vec_t;

    localparam int unsigned NV = 12;
    vec_t tbl [NV];

    localparam int unsigned NR = 40;
    logic [W-1:0] q [$];
    int unsigned  idx [F];
    int unsigned  pushed;
    bit           all_done;

    initial begin
        // inputs applied for one edge; expectations are the outputs after that edge
        tbl[0]  = '{1'b1, 8'hA5, ALL,      2'd1, ALL,      8'hA5, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, ALL,      2'd0, 20'h0,    8'h00, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'h11, 20'h003FF, 2'd1, ALL,     8'h11, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 20'h003FF, 2'd1, 20'hFFC00, 8'h11, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 20'h003FF, 2'd1, 20'hFFC00, 8'h11, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, ALL,      2'd0, 20'h0,    8'h00, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'h01, 20'h0,    2'd1, ALL,      8'h01, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 8'h02, 20'h0,    2'd2, ALL,      8'h01, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'h03, 20'h0,    2'd2, ALL,      8'h01, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h03, ALL,      2'd1, ALL,      8'h02, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 8'h03, ALL,      2'd1, ALL,      8'h03, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, ALL,      2'd0, 20'h0,    8'h00, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        #12 rst = 1'b0;
        cyc();

        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);

        for (int unsigned v = 0; v < NV; v++) begin
            in_valid  = tbl[v].iv;
            in_data   = tbl[v].d;
            out_ready = tbl[v].rdy;
            cyc();
            chk($sformatf("vec%0d_count", v), 32'(count), 32'(tbl[v].ecnt));
            chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(tbl[v].eov));
            chk($sformatf("vec%0d_pending", v), 32'(pending), 32'(tbl[v].eov));
            chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(tbl[v].eir));
            if (tbl[v].chkd) begin
                chk($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(tbl[v].edata));
            end
        end

        // streaming: one word per cycle through both FIFO slots and pointer wrap
        out_ready = ALL;
        for (int unsigned k = 0; k < 100; k++) begin
            in_valid = 1'b1;
            in_data  = W'(k + 8'h20);
            cyc();
            chk($sformatf("stream%0d_data", k), 32'(out_data), 32'(W'(k + 8'h20)));
            chk($sformatf("stream%0d_valid", k), 32'(out_valid), 32'(ALL));
            chk($sformatf("stream%0d_count", k), 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drain_count", 32'(count), 32'd0);
        chk("stream_drain_valid", 32'(out_valid), 32'd0);

        // asynchronous reset with two words stored and sinks 0..3 already served
        out_ready = '0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        cyc();
        in_data   = 8'hBB;
        cyc();
        in_valid  = 1'b0;
        out_ready = 20'h0000F;
        cyc();
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_pending", 32'(pending), 32'hFFFF0);
        out_ready = '0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_pending", 32'(pending), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_data", 32'(out_data), 32'd0);
        #3 rst = 1'b0;
        out_ready = ALL;
        for (int unsigned k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("post_rst%0d_valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("post_rst%0d_count", k), 32'(count), 32'd0);
        end

        // random per-sink ready against an ordered per-sink scoreboard
        pushed = 0;
        for (int unsigned i = 0; i < F; i++) idx[i] = 0;
        all_done = 1'b0;
        for (int unsigned c = 0; c < 3000 && !all_done; c++) begin
            in_valid  = (pushed < NR) && ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = F'($urandom);
            @(negedge clk);
            for (int unsigned i = 0; i < F; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (idx[i] >= q.size()) begin
                        chk($sformatf("rand_sink%0d_extra", i), 32'(idx[i]), 32'(q.size()));
                    end else begin
                        chk($sformatf("rand_sink%0d_w%0d", i, idx[i]), 32'(out_data), 32'(q[idx[i]]));
                    end
                    idx[i]++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                pushed++;
            end
            all_done = 1'b1;
            for (int unsigned i = 0; i < F; i++) begin
                if (idx[i] < NR) all_done = 1'b0;
            end
            cyc();
        end
        chk("rand_completed", 32'(all_done), 32'd1);
        for (int unsigned i = 0; i < F; i++) begin
            chk($sformatf("rand_sink%0d_total", i), 32'(idx[i]), 32'(NR));
        end
        in_valid  = 1'b0;
        out_ready = '0;
        cyc();
        chk("rand_end_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
